// File: rtl/mips_seq_controller.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mips_seq_controller
// Multi-cycle control sequencer for a 32-bit MIPS datapath. Fetches through a
// ready/request handshake, decodes the latched opcode/funct, runs the data
// memory handshake for lw/sw and pulses pc_en once per retired instruction.
// Illegal encodings and memory timeouts park the sequencer in TRAP until reset.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | imem_req high, wait for imem_ready, latch opcode/funct
// EXEC  | decode; ALU/branch/jump retire here, lw/sw move on to MEM
// MEM   | dmem_req high (dmem_we for sw); sw retires on dmem_ready
// WB    | lw register write-back and retire
// TRAP  | halted, err held, leave only through reset
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   instr, zero           instruction word, ALU zero flag
//   imem_req/imem_ready   instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready  data memory handshake
//   pc_en                 PC load pulse, one per retired instruction
//   reg_dst..pc_src       datapath controls, alu_control ALU opcode
//   err, halted           trap cause (01 illegal, 10 imem, 11 dmem), TRAP flag
// ---------------------------------------------------------------------------
module mips_seq_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src,
    output logic        jump,
    output logic        jal,
    output logic        jr,
    output logic        mem_to_reg,
    output logic        pc_src,
    output logic [3:0]  alu_control,
    output logic [1:0]  err,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_TRAP  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_IMEM    = 2'b10;
    localparam logic [1:0] ERR_DMEM    = 2'b11;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [5:0]       op_q, fn_q;
    logic [1:0]       err_q, err_nxt;
    logic             latch_load;
    logic             timeout_hit;

    // Only opcode and funct are decoded; the operand fields belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    // Decoded view of the latched instruction.
    logic       d_legal, d_lw, d_sw, d_beq, d_wr;
    logic       d_reg_dst, d_alu_src, d_mem_to_reg, d_jump, d_jal, d_jr;
    logic [3:0] d_alu;

    always_comb begin
        d_legal      = 1'b0;
        d_lw         = 1'b0;
        d_sw         = 1'b0;
        d_beq        = 1'b0;
        d_wr         = 1'b0;
        d_reg_dst    = 1'b0;
        d_alu_src    = 1'b0;
        d_mem_to_reg = 1'b0;
        d_jump       = 1'b0;
        d_jal        = 1'b0;
        d_jr         = 1'b0;
        d_alu        = 4'b0000;
        case (op_q)
            6'h00: begin
                d_legal   = 1'b1;
                d_reg_dst = 1'b1;
                d_wr      = 1'b1;
                case (fn_q)
                    6'h20: d_alu = 4'b0010;
                    6'h22: d_alu = 4'b0110;
                    6'h24: d_alu = 4'b0000;
                    6'h25: d_alu = 4'b0001;
                    6'h2A: d_alu = 4'b0111;
                    6'h00: d_alu = 4'b1000;
                    6'h02: d_alu = 4'b1001;
                    6'h08: begin
                        d_reg_dst = 1'b0;
                        d_wr      = 1'b0;
                        d_jr      = 1'b1;
                    end
                    default: begin
                        d_legal   = 1'b0;
                        d_reg_dst = 1'b0;
                        d_wr      = 1'b0;
                    end
                endcase
            end
            6'h23: begin
                d_legal      = 1'b1;
                d_lw         = 1'b1;
                d_alu_src    = 1'b1;
                d_mem_to_reg = 1'b1;
                d_alu        = 4'b0010;
            end
            6'h2B: begin
                d_legal   = 1'b1;
                d_sw      = 1'b1;
                d_alu_src = 1'b1;
                d_alu     = 4'b0010;
            end
            6'h08: begin
                d_legal   = 1'b1;
                d_alu_src = 1'b1;
                d_wr      = 1'b1;
                d_alu     = 4'b0010;
            end
            6'h04: begin
                d_legal = 1'b1;
                d_beq   = 1'b1;
                d_alu   = 4'b0110;
            end
            6'h02: begin
                d_legal = 1'b1;
                d_jump  = 1'b1;
            end
            6'h03: begin
                d_legal = 1'b1;
                d_jump  = 1'b1;
                d_jal   = 1'b1;
                d_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    // A ready in the threshold cycle is checked first, so it still completes.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        err_nxt     = err_q;
        latch_load  = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_en       = 1'b0;
        reg_write   = 1'b0;
        pc_src      = 1'b0;
        halted      = 1'b0;
        reg_dst     = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        jump        = 1'b0;
        jal         = 1'b0;
        jr          = 1'b0;
        alu_control = 4'b0000;

        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            reg_dst     = d_reg_dst;
            alu_src     = d_alu_src;
            mem_to_reg  = d_mem_to_reg;
            jump        = d_jump;
            jal         = d_jal;
            jr          = d_jr;
            alu_control = d_alu;
        end

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    latch_load = 1'b1;
                    wait_nxt   = '0;
                    state_nxt  = S_EXEC;
                end else if (timeout_hit) begin
                    err_nxt   = ERR_IMEM;
                    state_nxt = S_TRAP;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_EXEC: begin
                wait_nxt = '0;
                if (!d_legal) begin
                    err_nxt   = ERR_ILLEGAL;
                    state_nxt = S_TRAP;
                end else if (d_lw || d_sw) begin
                    state_nxt = S_MEM;
                end else begin
                    pc_en     = 1'b1;
                    reg_write = d_wr;
                    pc_src    = d_beq & zero;
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = d_sw;
                if (dmem_ready) begin
                    wait_nxt = '0;
                    if (d_sw) begin
                        pc_en     = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (timeout_hit) begin
                    err_nxt   = ERR_DMEM;
                    state_nxt = S_TRAP;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_en     = 1'b1;
                wait_nxt  = '0;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_TRAP;
            end
        endcase
    end

    assign err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            err_q    <= ERR_NONE;
            op_q     <= '0;
            fn_q     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            err_q    <= err_nxt;
            if (latch_load) begin
                op_q <= instr[31:26];
                fn_q <= instr[5:0];
            end
        end
    end

endmodule
